// File: rtl/imu_tagger_pkg.sv
// Shared constants and types for the IMU package tagger.
package imu_tagger_pkg;

    localparam int PKG_BYTES = 32;
    localparam int PKG_IDX_W = 5;

    // Axis byte offsets relative to the acceleration base bit (high byte first).
    localparam int AX_HI_OFF = 48;
    localparam int AX_LO_OFF = 56;
    localparam int AY_HI_OFF = 32;
    localparam int AY_LO_OFF = 40;
    localparam int AZ_HI_OFF = 16;
    localparam int AZ_LO_OFF = 24;

    localparam logic [7:0] DEFAULT_HEADER = 8'h55;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tagger_state_e;

endpackage

// File: rtl/imu_package_tagger_energy_square_sum.sv
// Two-stage acceleration energy: signed squares, then a widened sum.
// Kept separate so the three multipliers map cleanly onto DSP blocks.
module energy_square_sum #(
    parameter int SRC_W = 16,
    parameter int SUM_W = 2 * SRC_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SRC_W-1:0] ax,
    input  logic [SRC_W-1:0] ay,
    input  logic [SRC_W-1:0] az,
    input  logic             valid_in,
    output logic [SUM_W-1:0] energy,
    output logic             valid_out,
    output logic             sq_valid
);
    localparam int SQ_W = 2 * SRC_W;

    logic signed [SQ_W-1:0] ax_w, ay_w, az_w;
    logic [SQ_W-1:0]        sq_x, sq_y, sq_z;

    assign ax_w = SQ_W'($signed(ax));
    assign ay_w = SQ_W'($signed(ay));
    assign az_w = SQ_W'($signed(az));

    // Stage valids; cleared by reset so a partial pipeline never strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_valid  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            sq_valid  <= valid_in;
            valid_out <= sq_valid;
        end
    end

    // S1: squares (always non-negative, fit unsigned in 2*SRC_W bits).
    always_ff @(posedge clk) begin
        if (valid_in) begin
            sq_x <= ax_w * ax_w;
            sq_y <= ay_w * ay_w;
            sq_z <= az_w * az_w;
        end
    end

    // S2: sum with two guard bits so three squares cannot overflow.
    always_ff @(posedge clk) begin
        if (sq_valid) begin
            energy <= SUM_W'(sq_x) + SUM_W'(sq_y) + SUM_W'(sq_z);
        end
    end

endmodule

// File: rtl/imu_package_tagger.sv
// IMU package tagger: frames the sensor byte stream into 32-byte packages,
// flags packages whose acceleration energy reaches THRESHOLD and emits
// {package, flag} on a one-cycle write strobe.
// Optional: IMU_TAGGER_CHECKSUM_EN makes byte 31 a mod-256 checksum of
// bytes 0..30; mismatching packages are dropped.
//
// state   | meaning
// HUNT    | waiting for a HEADER byte to start a package
// COLLECT | storing bytes 1..31, watching the inter-byte timeout
module imu_package_tagger
    import imu_tagger_pkg::*;
#(
    parameter int          WINDOW_WIDTH          = 256,
    parameter int          A_OFFSET              = 2,
    parameter int          SQUARE_SRC_DATA_WIDTH = 16,
    parameter logic [31:0] THRESHOLD             = 32'h0010_0000,
    parameter logic [7:0]  HEADER                = DEFAULT_HEADER,
    parameter int          TIMEOUT_CYCLES        = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid,
    output logic [WINDOW_WIDTH:0]   data_o,
    output logic                    data_wen,
    output logic [15:0]             pkt_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    busy
);
    localparam int A_BIT = A_OFFSET << 6;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int SUM_W = 2 * SQUARE_SRC_DATA_WIDTH + 2;
    localparam logic [PKG_IDX_W-1:0] LAST_IDX = PKG_IDX_W'(PKG_BYTES - 1);
    localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    tagger_state_e state, state_nx;

    // Bytes 0..30 only; byte 31 goes straight into the pipeline latch.
    logic [WINDOW_WIDTH-9:0]          pkg_buf;
    logic [WINDOW_WIDTH-1:0]          pkg_s1;
    logic [PKG_IDX_W-1:0]             idx;
    logic [TO_W-1:0]                  to_cnt;
    logic                             store_en, handoff, drop, csum_ok;
    logic [SQUARE_SRC_DATA_WIDTH-1:0] ax, ay, az;
    logic [SUM_W-1:0]                 energy;
    logic                             energy_valid, sq_valid;

`ifdef IMU_TAGGER_CHECKSUM_EN
    logic [7:0] csum;

    // Running mod-256 sum of the bytes stored so far.
    always_ff @(posedge clk) begin
        if (!rst_n)
            csum <= 8'h00;
        else if (store_en)
            csum <= (state == HUNT) ? byte_i : csum + byte_i;
    end

    assign csum_ok = (byte_i == csum);
`else
    assign csum_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nx;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nx = state;
        store_en = 1'b0;
        handoff  = 1'b0;
        drop     = 1'b0;
        case (state)
            HUNT: begin
                if (byte_valid && byte_i == HEADER) begin
                    store_en = 1'b1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    store_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nx = HUNT;
                        handoff  = csum_ok;
                        drop     = !csum_ok;
                    end
                end else if (to_cnt == TO_MAX) begin
                    drop     = 1'b1;
                    state_nx = HUNT;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    // Byte index, inter-byte timeout and drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            to_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (handoff || drop)
                idx <= '0;
            else if (store_en)
                idx <= idx + 1'b1;
            if (store_en || state == HUNT)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            if (drop)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Package storage; no reset needed since every byte is rewritten per package.
    always_ff @(posedge clk) begin
        if (store_en && idx != LAST_IDX)
            pkg_buf[{idx, 3'b000} +: 8] <= byte_i;
        if (handoff)
            pkg_s1 <= {byte_i, pkg_buf};
    end

    // Axis words come from bytes 18..23, already stored when byte 31 arrives.
    assign ax = {pkg_buf[A_BIT + AX_HI_OFF +: 8], pkg_buf[A_BIT + AX_LO_OFF +: 8]};
    assign ay = {pkg_buf[A_BIT + AY_HI_OFF +: 8], pkg_buf[A_BIT + AY_LO_OFF +: 8]};
    assign az = {pkg_buf[A_BIT + AZ_HI_OFF +: 8], pkg_buf[A_BIT + AZ_LO_OFF +: 8]};

    energy_square_sum #(
        .SRC_W (SQUARE_SRC_DATA_WIDTH),
        .SUM_W (SUM_W)
    ) u_energy (
        .clk       (clk),
        .rst_n     (rst_n),
        .ax        (ax),
        .ay        (ay),
        .az        (az),
        .valid_in  (handoff),
        .energy    (energy),
        .valid_out (energy_valid),
        .sq_valid  (sq_valid)
    );

    // S3: threshold flag, output register and package counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o   <= '0;
            data_wen <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            data_wen <= energy_valid;
            if (energy_valid) begin
                data_o  <= {pkg_s1, energy >= SUM_W'(THRESHOLD)};
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    assign busy = (state == COLLECT) | sq_valid | energy_valid | data_wen;

endmodule

// File: tb/tb_imu_package_tagger.sv
// Bench for imu_package_tagger: a queue-based model of package framing,
// energy arithmetic and strobe timing, checked every cycle, plus directed
// cases with hand-computed expectations.
module tb_imu_package_tagger;

    localparam int TIMEOUT = 1024;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_i;
    logic         byte_valid;
    logic [256:0] data_o;
    logic         data_wen;
    logic [15:0]  pkt_cnt;
    logic [15:0]  drop_cnt;
    logic         busy;

    imu_package_tagger dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_i     (byte_i),
        .byte_valid (byte_valid),
        .data_o     (data_o),
        .data_wen   (data_wen),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           rem;
        logic [256:0] val;
    } pend_t;

    pend_t        pend_q[$];
    logic [7:0]   m_q[$];
    bit           m_collect;
    int           m_idle;
    logic         exp_wen;
    logic [256:0] exp_data;
    logic [15:0]  exp_pkt;
    logic [15:0]  exp_drop;
    logic         exp_busy;

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        logic [255:0] pv;
        longint       e;
        int           ax, ay, az;
        logic [7:0]   s;
        bit           ok;
        exp_wen = 1'b0;
        if (rst_n !== 1'b1) begin
            m_collect = 0;
            m_q.delete();
            m_idle    = 0;
            pend_q.delete();
            exp_data  = '0;
            exp_pkt   = '0;
            exp_drop  = '0;
            exp_busy  = 1'b0;
            return;
        end
        for (int i = 0; i < pend_q.size(); i++) pend_q[i].rem--;
        if (pend_q.size() > 0 && pend_q[0].rem <= 0) begin
            exp_wen  = 1'b1;
            exp_data = pend_q[0].val;
            exp_pkt++;
            pend_q.delete(0);
        end
        if (!m_collect) begin
            if (byte_valid && byte_i == 8'h55) begin
                m_q.delete();
                m_q.push_back(byte_i);
                m_collect = 1;
                m_idle    = 0;
            end
        end else if (byte_valid) begin
            m_q.push_back(byte_i);
            m_idle = 0;
            if (m_q.size() == 32) begin
                m_collect = 0;
                ok = 1;
`ifdef IMU_TAGGER_CHECKSUM_EN
                s = 8'h00;
                for (int k = 0; k < 31; k++) s = s + m_q[k];
                ok = (s == m_q[31]);
`endif
                if (ok) begin
                    for (int k = 0; k < 32; k++) pv[8*k +: 8] = m_q[k];
                    ax = int'($signed({m_q[22], m_q[23]}));
                    ay = int'($signed({m_q[20], m_q[21]}));
                    az = int'($signed({m_q[18], m_q[19]}));
                    e  = longint'(ax * ax) + longint'(ay * ay) + longint'(az * az);
                    pend_q.push_back('{rem: 2, val: {pv, (e >= 64'h0010_0000)}});
                end else begin
                    exp_drop++;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_collect = 0;
                exp_drop++;
            end
        end
        exp_busy = m_collect || (pend_q.size() > 0) || exp_wen;
    endtask

    // Single compare process: check outputs mid-cycle, then advance the model.
    initial begin
        #1;
        model_step();
        forever begin
            @(negedge clk);
            check16("data_wen", {15'b0, data_wen}, {15'b0, exp_wen});
            check("data_o", data_o, exp_data);
            check16("pkt_cnt", pkt_cnt, exp_pkt);
            check16("drop_cnt", drop_cnt, exp_drop);
            check16("busy", {15'b0, busy}, {15'b0, exp_busy});
            model_step();
        end
    end

    // Strobe log for timing checks between packages.
    int cyc_n = 0;
    int wen_t[$];
    bit wen_f[$];
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) begin
        if (data_wen === 1'b1) begin
            wen_t.push_back(cyc_n);
            wen_f.push_back(data_o[0]);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pk[32];
    logic [7:0] pa[32];
    logic [7:0] pb[32];

    task automatic drive(input logic v, input logic [7:0] b);
        byte_valid = v;
        byte_i     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic build(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
        logic [7:0] s;
        pk[0] = 8'h55;
        for (int k = 1; k < 31; k++) pk[k] = 8'($urandom_range(0, 255));
        pk[22] = ax[15:8]; pk[23] = ax[7:0];
        pk[20] = ay[15:8]; pk[21] = ay[7:0];
        pk[18] = az[15:8]; pk[19] = az[7:0];
        s = 8'h00;
        for (int k = 0; k < 31; k++) s = s + pk[k];
        pk[31] = s;
    endtask

    function automatic logic [255:0] pkg_vec();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = pk[k];
        return v;
    endfunction

    task automatic send_pkg(input int gap_max);
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, pk[k]);
            if (k < 31 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_and_check(input string name, input logic flag, input logic [15:0] pkt);
        int n = 0;
        while (data_wen !== 1'b1 && n < 10) begin
            idle(1);
            n++;
        end
        check16({name, " latency"}, 16'(n + 1), 16'd3);
        check16({name, " flag"}, {15'b0, data_o[0]}, {15'b0, flag});
        check({name, " payload"}, {1'b0, data_o[256:1]}, {1'b0, pkg_vec()});
        check16({name, " pkt_cnt"}, pkt_cnt, pkt);
    endtask

    initial begin
        int n0;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_i     = 8'h00;
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        rst_n = 1'b1;
        idle(2);
        check("reset data_o", data_o, '0);
        check16("reset pkt_cnt", pkt_cnt, 16'd0);
        check16("reset busy", {15'b0, busy}, 16'd0);

        // energy exactly at threshold
        build(16'h0400, 16'h0000, 16'h0000);
        send_pkg(0);
        wait_and_check("thr_eq", 1'b1, 16'd1);
        idle(3);
        // one LSB below threshold
        build(16'h03FF, 16'h0000, 16'h0000);
        send_pkg(2);
        wait_and_check("thr_below", 1'b0, 16'd2);
        idle(3);
        // most negative on every axis
        build(16'h8000, 16'h8000, 16'h8000);
        send_pkg(0);
        wait_and_check("max_neg", 1'b1, 16'd3);
        idle(3);

        // leading junk is ignored
        n0 = wen_t.size();
        drive(1'b1, 8'h12);
        drive(1'b1, 8'h34);
        build(16'h0001, 16'hFFFF, 16'h0002);
        send_pkg(0);
        wait_and_check("junk", 1'b0, 16'd4);
        idle(5);
        check16("junk strobes", 16'(wen_t.size() - n0), 16'd1);
        check16("junk drop_cnt", drop_cnt, 16'd0);

        // timeout boundary: 1023 idle still collecting, 1024th drops
        build(16'h2000, 16'h0000, 16'h0000);
        for (int k = 0; k < 10; k++) drive(1'b1, pk[k]);
        idle(TIMEOUT - 1);
        check16("to_1023 drop", drop_cnt, 16'd0);
        check16("to_1023 busy", {15'b0, busy}, 16'd1);
        idle(1);
        check16("to_1024 drop", drop_cnt, 16'd1);
        check16("to_1024 busy", {15'b0, busy}, 16'd0);
        check16("to pkt_cnt", pkt_cnt, 16'd4);
        build(16'h0000, 16'h0400, 16'h0000);
        send_pkg(0);
        wait_and_check("after_to", 1'b1, 16'd5);
        idle(3);

        // a 1023-cycle gap inside a package is tolerated
        build(16'h0000, 16'h0000, 16'h0500);
        for (int k = 0; k < 11; k++) drive(1'b1, pk[k]);
        idle(TIMEOUT - 1);
        for (int k = 11; k < 32; k++) drive(1'b1, pk[k]);
        wait_and_check("gap_1023", 1'b1, 16'd6);
        check16("gap_1023 drop", drop_cnt, 16'd1);
        idle(3);

        // back-to-back, then reset in the middle of a third package
        n0 = wen_t.size();
        build(16'h0400, 16'h0000, 16'h0000);
        pa = pk;
        build(16'h0100, 16'h0000, 16'h0000);
        pk[5] = 8'h55;
        pk[31] = pk[31] + 8'h55 - pa[5];
        pk[31] = 8'h00;
        for (int k = 0; k < 31; k++) pk[31] = pk[31] + pk[k];
        pb = pk;
        for (int k = 0; k < 32; k++) drive(1'b1, pa[k]);
        for (int k = 0; k < 32; k++) drive(1'b1, pb[k]);
        build(16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int k = 0; k < 20; k++) drive(1'b1, pk[k]);
        rst_n = 1'b0;
        drive(1'b1, pk[20]);
        drive(1'b1, pk[21]);
        rst_n = 1'b1;
        idle(10);
        check16("b2b strobes", 16'(wen_t.size() - n0), 16'd2);
        if (wen_t.size() >= n0 + 2) begin
            check16("b2b spacing", 16'(wen_t[n0 + 1] - wen_t[n0]), 16'd32);
            check16("b2b flag0", {15'b0, wen_f[n0]}, 16'd1);
            check16("b2b flag1", {15'b0, wen_f[n0 + 1]}, 16'd0);
        end
        check16("rst pkt_cnt", pkt_cnt, 16'd0);
        check16("rst drop_cnt", drop_cnt, 16'd0);
        check16("rst busy", {15'b0, busy}, 16'd0);

        // checksum off by one, then correct
        n0 = wen_t.size();
        build(16'h0400, 16'h0400, 16'h0000);
        pk[31] = pk[31] + 8'd1;
        send_pkg(0);
        idle(6);
`ifdef IMU_TAGGER_CHECKSUM_EN
        check16("csum_bad drop", drop_cnt, 16'd1);
        check16("csum_bad strobes", 16'(wen_t.size() - n0), 16'd0);
        build(16'h0400, 16'h0400, 16'h0000);
        send_pkg(0);
        wait_and_check("csum_good", 1'b1, 16'd1);
`else
        check16("csum_bad drop", drop_cnt, 16'd0);
        check16("csum_bad strobes", 16'(wen_t.size() - n0), 16'd1);
        check16("csum_bad pkt", pkt_cnt, 16'd1);
`endif
        idle(4);

        // randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            int jn;
            int mode;
            int kk;
            logic [7:0] b;
            jn = $urandom_range(0, 2);
            for (int j = 0; j < jn; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h54;
                drive(1'b1, b);
            end
            build(16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 4) == 0) pk[31] = pk[31] + 8'd1;
            mode = $urandom_range(0, 9);
            kk   = $urandom_range(1, 30);
            if (mode == 0) begin
                for (int k = 0; k < kk; k++) drive(1'b1, pk[k]);
                idle(TIMEOUT + $urandom_range(0, 3));
            end else if (mode == 1) begin
                for (int k = 0; k < kk; k++) drive(1'b1, pk[k]);
                rst_n = 1'b0;
                drive(1'($urandom_range(0, 1)), pk[kk]);
                rst_n = 1'b1;
            end else begin
                send_pkg(mode == 2 ? 5 : 1);
            end
            idle($urandom_range(0, 4));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
